// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_sequencer
//  Description : Control stage for an 8:1 mux (74151 style). Latches a word
//                onto I7..I0, walks select C,B,A over all eight indices,
//                samples Z back into a capture word and flags mismatches.
//                Optional parity compare: define MUX_SCAN_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer #(
    parameter int SETTLE   = 2,
    parameter bit START_UP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dir,
    input  logic       continuous,
    input  logic [7:0] data_in,
    input  logic       z_in,
    output logic [7:0] i_out,
    output logic       sel_c,
    output logic       sel_b,
    output logic       sel_a,
    output logic       strobe,
    output logic       busy,
    output logic       done,
    output logic [7:0] cap_word,
    output logic       mismatch,
    output logic       parity_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last settle count before sampling, and the idle/reset select index.
    localparam logic [3:0] c_LAST_CNT = 4'(SETTLE - 1);
    localparam logic [2:0] c_IDLE_IDX = START_UP ? 3'd0 : 3'd7;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_dir;
    logic [7:0] r_iout;
    logic [7:0] r_cap;
    logic       r_mismatch;

    logic       w_sample;
    logic [2:0] w_last_idx;

    // Sample point: end of the settle window for the current index.
    assign w_sample   = (r_state == ST_SCAN) && (r_cnt == c_LAST_CNT) && !abort;
    assign w_last_idx = r_dir ? 3'd0 : 3'd7;

    // Frame sequencer: latches data, steps select, captures Z, checks result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= c_IDLE_IDX;
            r_cnt      <= 4'd0;
            r_dir      <= 1'b0;
            r_iout     <= 8'd0;
            r_cap      <= 8'd0;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // start wins over abort while idle
                    if (start) begin
                        r_iout  <= data_in;
                        r_dir   <= dir;
                        r_idx   <= dir ? 3'd7 : 3'd0;
                        r_cnt   <= 4'd0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        r_idx   <= c_IDLE_IDX;
                        r_state <= ST_IDLE;
                    end else if (w_sample) begin
                        r_cap[r_idx] <= z_in;
                        if (r_idx == w_last_idx) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_dir ? (r_idx - 3'd1) : (r_idx + 3'd1);
                            r_cnt <= 4'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        r_idx   <= c_IDLE_IDX;
                        r_state <= ST_IDLE;
                    end else begin
                        // cap_word already holds the final sample here
                        r_mismatch <= (r_cap != r_iout);
                        if (continuous) begin
                            r_iout  <= data_in;
                            r_dir   <= dir;
                            r_idx   <= dir ? 3'd7 : 3'd0;
                            r_cnt   <= 4'd0;
                            r_state <= ST_SCAN;
                        end else begin
                            r_idx   <= c_IDLE_IDX;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_idx   <= c_IDLE_IDX;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_parity;

    // Parity difference between captured and driven word, updated with mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if ((r_state == ST_DONE) && !abort) begin
            r_parity <= (^r_cap) ^ (^r_iout);
        end
    end

    assign parity_err = r_parity;
`else
    assign parity_err = 1'b0;
`endif

    assign i_out    = r_iout;
    assign {sel_c, sel_b, sel_a} = r_idx;
    assign strobe   = w_sample;
    assign busy     = (r_state == ST_SCAN);
    assign done     = (r_state == ST_DONE) && !abort;
    assign cap_word = r_cap;
    assign mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_sequencer
//  Description : Directed self-checking bench for mux_scan_sequencer with an
//                ideal 8:1 mux model closing the Z loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_PARITY_EN
    localparam logic c_PAR = 1'b1;
`else
    localparam logic c_PAR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dir;
    logic       continuous;
    logic [7:0] data_in;
    logic       z_in;
    logic [7:0] i_out;
    logic       sel_c;
    logic       sel_b;
    logic       sel_a;
    logic       strobe;
    logic       busy;
    logic       done;
    logic [7:0] cap_word;
    logic       mismatch;
    logic       parity_err;

    logic       fault;
    logic [2:0] w_sel;
    int         n_tests;
    int         n_fail;

    mux_scan_sequencer #(
        .SETTLE   (2),
        .START_UP (1'b1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .dir        (dir),
        .continuous (continuous),
        .data_in    (data_in),
        .z_in       (z_in),
        .i_out      (i_out),
        .sel_c      (sel_c),
        .sel_b      (sel_b),
        .sel_a      (sel_a),
        .strobe     (strobe),
        .busy       (busy),
        .done       (done),
        .cap_word   (cap_word),
        .mismatch   (mismatch),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_sel = {sel_c, sel_b, sel_a};

    // Ideal mux, with an optional stuck-at-0 on index 2
    always_comb begin
        z_in = i_out[w_sel];
        if (fault && (w_sel == 3'd2)) z_in = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] e_sel;
        int         n_strb;
        logic       saw_done;

        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0;
        continuous = 1'b0; data_in = 8'h00; fault = 1'b0;

        // ---- asynchronous reset, checked before any clock edge ----
        #2 rst_n = 1'b0;
        #1;
        chk8("rst_i_out", i_out, 8'h00);
        chk8("rst_cap", cap_word, 8'h00);
        chk8("rst_sel", {5'd0, w_sel}, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_strobe", strobe, 1'b0);
        chk1("rst_mismatch", mismatch, 1'b0);
        chk1("rst_parity", parity_err, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---- up scan of A5 ----
        data_in = 8'hA5; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_strb = 0;
        for (int c = 1; c <= 16; c++) begin
            e_sel = 8'((c - 1) / 2);
            chk8("up_sel", {5'd0, w_sel}, e_sel);
            chk1("up_strobe", strobe, ((c - 1) % 2) == 1);
            chk1("up_busy", busy, 1'b1);
            if (strobe) n_strb++;
            tick();
        end
        chk8("up_strobe_count", 8'(n_strb), 8'd8);
        chk1("up_done", done, 1'b1);
        chk1("up_busy17", busy, 1'b0);
        chk8("up_i_out", i_out, 8'hA5);
        chk8("up_cap", cap_word, 8'hA5);
        tick();
        chk1("up_done_pulse", done, 1'b0);
        chk1("up_mismatch", mismatch, 1'b0);
        chk1("up_parity", parity_err, 1'b0);
        chk8("up_idle_sel", {5'd0, w_sel}, 8'h00);

        // ---- down scan of 3C with index 2 stuck low ----
        data_in = 8'h3C; dir = 1'b1; fault = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            e_sel = 8'(7 - (c - 1) / 2);
            chk8("dn_sel", {5'd0, w_sel}, e_sel);
            tick();
        end
        chk1("dn_done", done, 1'b1);
        chk8("dn_cap", cap_word, 8'h38);
        tick();
        fault = 1'b0;
        chk1("dn_mismatch", mismatch, 1'b1);
        chk1("dn_parity", parity_err, c_PAR);
        chk8("dn_idle_sel", {5'd0, w_sel}, 8'h00);

        // ---- abort in cycle 6, start while busy ignored ----
        data_in = 8'hFF; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk1("ab_busy", busy, 1'b1);
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        chk8("ab_sel6", {5'd0, w_sel}, 8'h02);
        abort = 1'b1;
        #1;
        chk1("ab_strobe_sup", strobe, 1'b0);
        chk1("ab_done_sup", done, 1'b0);
        tick();
        abort = 1'b0;
        chk1("ab_busy7", busy, 1'b0);
        chk8("ab_sel7", {5'd0, w_sel}, 8'h00);
        chk1("ab_mismatch", mismatch, 1'b1);
        chk1("ab_parity", parity_err, c_PAR);
        chk8("ab_cap", cap_word, 8'h3B);
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        chk1("ab_no_done", saw_done, 1'b0);

        // ---- reset in the middle of a frame ----
        data_in = 8'h55; dir = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk8("mr_sel", {5'd0, w_sel}, 8'h06);
        #3 rst_n = 1'b0;
        #1;
        chk8("mr_i_out", i_out, 8'h00);
        chk8("mr_cap", cap_word, 8'h00);
        chk8("mr_sel0", {5'd0, w_sel}, 8'h00);
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_mismatch", mismatch, 1'b0);
        chk1("mr_parity", parity_err, 1'b0);
        tick();
        #2 rst_n = 1'b1;
        tick();

        // ---- continuous: 0F then F0 back to back ----
        data_in = 8'h0F; dir = 1'b0; continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        data_in = 8'hF0;
        for (int c = 1; c <= 16; c++) begin
            chk1("ct1_busy", busy, 1'b1);
            chk8("ct1_i_out", i_out, 8'h0F);
            tick();
        end
        chk1("ct_done17", done, 1'b1);
        chk1("ct_busy17", busy, 1'b0);
        chk8("ct_cap17", cap_word, 8'h0F);
        tick();
        continuous = 1'b0;
        chk1("ct_busy18", busy, 1'b1);
        chk1("ct_done18", done, 1'b0);
        chk8("ct2_i_out", i_out, 8'hF0);
        chk1("ct_mismatch1", mismatch, 1'b0);
        for (int c = 18; c <= 33; c++) begin
            chk1("ct2_busy", busy, 1'b1);
            tick();
        end
        chk1("ct_done34", done, 1'b1);
        chk8("ct_cap34", cap_word, 8'hF0);
        tick();
        chk1("ct_busy35", busy, 1'b0);
        chk1("ct_done35", done, 1'b0);
        chk1("ct_mismatch2", mismatch, 1'b0);
        chk8("ct_sel35", {5'd0, w_sel}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
